// File: rtl/samples_mem_hex_dump.sv
// samples_mem_hex_dump
// Reads a byte range from a synchronous-read memory (data one cycle after
// mem_rd) and streams it as Intel HEX text over a valid/ready character
// interface. Data records carry up to REC_LEN bytes and the stream ends with
// an EOF record.
// Build option: define HEX_CRLF_EN for CR LF line ends; otherwise LF only.
module samples_mem_hex_dump #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int REC_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           start_addr,
  input  logic [15:0]           length,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_ONE   = 8'h31;
  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_LF    = 8'h0A;
`ifdef HEX_CRLF_EN
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [3:0] EOF_LAST = 4'd12;
`else
  localparam logic [3:0] EOF_LAST = 4'd11;
`endif

  typedef enum logic [4:0] {
    S_IDLE,
    S_COLON,
    S_LEN_HI,
    S_LEN_LO,
    S_ADDR3,
    S_ADDR2,
    S_ADDR1,
    S_ADDR0,
    S_TYPE_HI,
    S_TYPE_LO,
    S_FETCH,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM_HI,
    S_CSUM_LO,
    S_EOL,
    S_EOF_REC,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [15:0]           cur_addr;   // address of the next byte to read
  logic [15:0]           rem;        // bytes not yet read
  logic [7:0]            ll;         // byte count of the current record
  logic [7:0]            rec_left;   // bytes of the current record not yet read
  logic [7:0]            sum;        // running record sum for the checksum
  logic [7:0]            csum;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            eof_idx, eof_idx_nx;
  logic [7:0]            start_ll, rec_ll;
  logic                  ld_start, ld_rec, do_fetch, fire, line_end;
`ifdef HEX_CRLF_EN
  logic                  eol_lf, eol_lf_nx;
`endif

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] rec_len_of(input logic [15:0] r);
    if (r < 16'(REC_LEN)) return r[7:0];
    return 8'(REC_LEN);
  endfunction

  // Fixed EOF record ":00000001FF" followed by the line end
  function automatic logic [7:0] eof_char(input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd0:       c = CH_COLON;
      4'd8:       c = CH_ONE;
      4'd9, 4'd10: c = CH_F;
`ifdef HEX_CRLF_EN
      4'd11:      c = CH_CR;
`endif
      default:    c = (idx > 4'd10) ? CH_LF : CH_ZERO;
    endcase
    return c;
  endfunction

  assign start_ll = rec_len_of(length);
  assign rec_ll   = rec_len_of(rem);
  assign csum     = 8'd0 - sum;
  assign mem_addr = cur_addr[ADDR_WIDTH-1:0];
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign fire     = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Character presented in each state; held as long as the state holds
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    case (state)
      S_COLON:   begin out_valid = 1'b1; out_data = CH_COLON;               end
      S_LEN_HI:  begin out_valid = 1'b1; out_data = hex_ch(ll[7:4]);        end
      S_LEN_LO:  begin out_valid = 1'b1; out_data = hex_ch(ll[3:0]);        end
      S_ADDR3:   begin out_valid = 1'b1; out_data = hex_ch(cur_addr[15:12]); end
      S_ADDR2:   begin out_valid = 1'b1; out_data = hex_ch(cur_addr[11:8]);  end
      S_ADDR1:   begin out_valid = 1'b1; out_data = hex_ch(cur_addr[7:4]);   end
      S_ADDR0:   begin out_valid = 1'b1; out_data = hex_ch(cur_addr[3:0]);   end
      S_TYPE_HI,
      S_TYPE_LO: begin out_valid = 1'b1; out_data = CH_ZERO;                end
      S_DATA_HI: begin out_valid = 1'b1; out_data = hex_ch(data_q[7:4]);    end
      S_DATA_LO: begin out_valid = 1'b1; out_data = hex_ch(data_q[3:0]);    end
      S_CSUM_HI: begin out_valid = 1'b1; out_data = hex_ch(csum[7:4]);      end
      S_CSUM_LO: begin out_valid = 1'b1; out_data = hex_ch(csum[3:0]);      end
      S_EOL: begin
        out_valid = 1'b1;
`ifdef HEX_CRLF_EN
        out_data  = eol_lf ? CH_LF : CH_CR;
`else
        out_data  = CH_LF;
`endif
      end
      S_EOF_REC: begin out_valid = 1'b1; out_data = eof_char(eof_idx);      end
      default: ;
    endcase
  end

  // Next state and datapath strobes. The read is issued on the handshake
  // that leaves TYPE_LO/DATA_LO so FETCH can capture the returned byte,
  // costing only one idle cycle per byte.
  always_comb begin
    state_nx   = state;
    mem_rd     = 1'b0;
    ld_start   = 1'b0;
    ld_rec     = 1'b0;
    do_fetch   = 1'b0;
    line_end   = 1'b0;
    eof_idx_nx = eof_idx;
`ifdef HEX_CRLF_EN
    eol_lf_nx  = eol_lf;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          ld_start = 1'b1;
          state_nx = S_COLON;
        end
      end
      S_COLON: begin
        if (fire) begin
          // Only a zero-length dump reaches COLON with nothing left; the
          // colon just sent opens the EOF record.
          if (rem == 16'd0) begin
            eof_idx_nx = 4'd1;
            state_nx   = S_EOF_REC;
          end else begin
            state_nx = S_LEN_HI;
          end
        end
      end
      S_LEN_HI:  if (fire) state_nx = S_LEN_LO;
      S_LEN_LO:  if (fire) state_nx = S_ADDR3;
      S_ADDR3:   if (fire) state_nx = S_ADDR2;
      S_ADDR2:   if (fire) state_nx = S_ADDR1;
      S_ADDR1:   if (fire) state_nx = S_ADDR0;
      S_ADDR0:   if (fire) state_nx = S_TYPE_HI;
      S_TYPE_HI: if (fire) state_nx = S_TYPE_LO;
      S_TYPE_LO: begin
        if (fire) begin
          if (ll != 8'd0) begin
            mem_rd   = 1'b1;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_CSUM_HI;
          end
        end
      end
      S_FETCH: begin
        do_fetch = 1'b1;
        state_nx = S_DATA_HI;
      end
      S_DATA_HI: if (fire) state_nx = S_DATA_LO;
      S_DATA_LO: begin
        if (fire) begin
          if (rec_left != 8'd0) begin
            mem_rd   = 1'b1;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_CSUM_HI;
          end
        end
      end
      S_CSUM_HI: if (fire) state_nx = S_CSUM_LO;
      S_CSUM_LO: if (fire) state_nx = S_EOL;
      S_EOL: begin
`ifdef HEX_CRLF_EN
        if (fire) eol_lf_nx = ~eol_lf;
        line_end = fire & eol_lf;
`else
        line_end = fire;
`endif
        if (line_end) begin
          if (rem != 16'd0) begin
            ld_rec   = 1'b1;
            state_nx = S_COLON;
          end else begin
            eof_idx_nx = 4'd0;
            state_nx   = S_EOF_REC;
          end
        end
      end
      S_EOF_REC: begin
        if (fire) begin
          if (eof_idx == EOF_LAST) begin
            eof_idx_nx = 4'd0;
            state_nx   = S_DONE;
          end else begin
            eof_idx_nx = eof_idx + 4'd1;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Dump bookkeeping: latch request, set up each record, consume fetched bytes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr <= '0;
      rem      <= '0;
      ll       <= '0;
      rec_left <= '0;
      sum      <= '0;
      data_q   <= '0;
      eof_idx  <= '0;
    end else begin
      eof_idx <= eof_idx_nx;
      if (ld_start) begin
        cur_addr <= start_addr;
        rem      <= length;
        ll       <= start_ll;
        rec_left <= start_ll;
        sum      <= start_ll + start_addr[15:8] + start_addr[7:0];
      end else if (ld_rec) begin
        ll       <= rec_ll;
        rec_left <= rec_ll;
        sum      <= rec_ll + cur_addr[15:8] + cur_addr[7:0];
      end else if (do_fetch) begin
        data_q   <= mem_data;
        sum      <= sum + mem_data;
        cur_addr <= cur_addr + 16'd1;
        rem      <= rem - 16'd1;
        rec_left <= rec_left - 8'd1;
      end
    end
  end

`ifdef HEX_CRLF_EN
  // Tracks whether the CR of the current line end has been sent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) eol_lf <= 1'b0;
    else       eol_lf <= eol_lf_nx;
  end
`endif

endmodule

// File: tb/tb_samples_mem_hex_dump.sv
// Self-checking bench for samples_mem_hex_dump: captures the character stream
// and compares it with an Intel HEX stream built from the memory contents.
module tb_samples_mem_hex_dump;

  localparam int AW    = 13;
  localparam int RL    = 16;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   start_addr;
  logic [15:0]   length;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_data = '0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  samples_mem_hex_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .REC_LEN(RL)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .length(length), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [MEMSZ];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  int total = 0;
  int bad   = 0;

  logic [7:0]    got_q[$];
  logic [7:0]    exp_q[$];
  logic [AW-1:0] rd_addr_q[$];
  int   rd_count, done_count, stab_bad, gap_count;
  bit   mon_en = 0;
  bit   held_pending;
  logic [7:0] held_data;
  logic busy_after_start, busy_after_done;
  string eol_s;

  // Observe the interface mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (held_pending && (out_valid !== 1'b1 || out_data !== held_data)) stab_bad++;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (mem_rd) begin rd_count++; rd_addr_q.push_back(mem_addr); end
      if (done) done_count++;
      if (busy && out_ready && !out_valid) gap_count++;
      held_pending = out_valid && !out_ready;
      held_data    = out_data;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] hexc(input int v);
    int n = v & 15;
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  task automatic push_hex(input int b);
    exp_q.push_back(hexc(b >> 4));
    exp_q.push_back(hexc(b));
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic model(input int sa, input int len);
    int emitted, addr, n, s, b;
    exp_q.delete();
    emitted = 0;
    while (emitted < len) begin
      addr = (sa + emitted) % 65536;
      n    = (len - emitted < RL) ? len - emitted : RL;
      s    = n + addr / 256 + addr % 256;
      push_str(":");
      push_hex(n); push_hex(addr / 256); push_hex(addr % 256); push_hex(0);
      for (int i = 0; i < n; i++) begin
        b = int'(mem[(addr + i) % MEMSZ]);
        push_hex(b);
        s += b;
      end
      push_hex((256 - s % 256) % 256);
      push_str(eol_s);
      emitted += n;
    end
    push_str(":00000001FF");
    push_str(eol_s);
  endtask

  function automatic int first_diff(output int g, output int e);
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    g = -1; e = -1;
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) begin g = int'(got_q[i]); e = int'(exp_q[i]); return i; end
    if (got_q.size() != exp_q.size()) begin
      if (n < got_q.size()) g = int'(got_q[n]);
      if (n < exp_q.size()) e = int'(exp_q[n]);
      return n;
    end
    return -1;
  endfunction

  // rmode: 0 ready always, 1 random ready, 2 one 5-cycle stall mid-data
  task automatic run_dump(input logic [15:0] sa, input logic [15:0] len,
                          input int rmode, input bit noise, output bit to);
    int cyc, stall_left;
    bit stalled;
    got_q.delete(); rd_addr_q.delete();
    rd_count = 0; done_count = 0; stab_bad = 0; gap_count = 0; held_pending = 0;
    stalled = 0; stall_left = 0;
    @(posedge clk); #1;
    out_ready = 1; start_addr = sa; length = len; start = 1; mon_en = 1;
    @(posedge clk); #1;
    busy_after_start = busy;
    start = 0; start_addr = 16'($urandom); length = 16'($urandom);
    cyc = 0;
    while (done_count == 0 && cyc < 300 + 24 * int'(len)) begin
      if (noise) begin
        start = ($urandom_range(0, 3) == 0);
        start_addr = 16'($urandom); length = 16'($urandom);
      end
      case (rmode)
        0: out_ready = 1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (!stalled && got_q.size() >= 12) begin stalled = 1; stall_left = 5; end
          if (stall_left > 0) begin out_ready = 0; stall_left--; end
          else out_ready = 1;
        end
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    start = 0; out_ready = 1;
    to = (done_count == 0);
    repeat (3) @(posedge clk);
    #1;
    busy_after_done = busy;
    mon_en = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b exp=0", mem_rd); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    @(negedge clk) reset = 0;
  endtask

  task automatic test_spec_example;
    bit to; int d, g, e;
    mem[0] = 8'h3E; mem[1] = 8'h55;
    exp_q.delete();
    push_str({":020000003E556B", eol_s, ":00000001FF", eol_s});
    run_dump(16'h0000, 16'd2, 0, 0, to);
    total++; if (to) begin bad++; $display("FAIL example_timeout got=no_done exp=done"); end
    total++; d = first_diff(g, e);
    if (d != -1) begin bad++; $display("FAIL example_stream at=%0d got=%0d exp=%0d", d, g, e); end
    total++; if (done_count != 1) begin bad++; $display("FAIL example_done got=%0d exp=1", done_count); end
    total++; if (rd_count != 2) begin bad++; $display("FAIL example_rd got=%0d exp=2", rd_count); end
    total++; if (busy_after_start !== 1'b1) begin bad++; $display("FAIL example_busy got=%b exp=1", busy_after_start); end
    total++; if (busy_after_done !== 1'b0) begin bad++; $display("FAIL example_idle got=%b exp=0", busy_after_done); end
    total++; if (gap_count > 2) begin bad++; $display("FAIL example_gaps got=%0d exp<=2", gap_count); end
  endtask

  task automatic test_zero_length;
    bit to; int d, g, e;
    exp_q.delete();
    push_str({":00000001FF", eol_s});
    run_dump(16'h1234, 16'd0, 0, 0, to);
    total++; d = first_diff(g, e);
    if (to || d != -1) begin bad++; $display("FAIL zero_stream at=%0d got=%0d exp=%0d to=%b", d, g, e, to); end
    total++; if (rd_count != 0) begin bad++; $display("FAIL zero_rd got=%0d exp=0", rd_count); end
    total++; if (done_count != 1) begin bad++; $display("FAIL zero_done got=%0d exp=1", done_count); end
  endtask

  task automatic test_multi_record;
    bit to; int d, g, e, off, hb;
    string h1, h2;
    h1 = ":10010000"; h2 = ":01011000";
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    model(32'h0100, 17);
    run_dump(16'h0100, 16'd17, 0, 0, to);
    total++; d = first_diff(g, e);
    if (to || d != -1) begin bad++; $display("FAIL multi_stream at=%0d got=%0d exp=%0d to=%b", d, g, e, to); end
    off = 9 + 32 + 2 + eol_s.len();
    hb = 0;
    for (int i = 0; i < 9; i++) begin
      if (i >= got_q.size() || got_q[i] !== h1[i]) hb++;
      if (off + i >= got_q.size() || got_q[off + i] !== h2[i]) hb++;
    end
    total++; if (hb != 0) begin bad++; $display("FAIL multi_headers got=%0d_bad_chars exp=0", hb); end
    total++; if (rd_count != 17) begin bad++; $display("FAIL multi_rd got=%0d exp=17", rd_count); end
    total++; if (gap_count > 17) begin bad++; $display("FAIL multi_gaps got=%0d exp<=17", gap_count); end
  endtask

  task automatic test_addr_wrap;
    bit to; int d, g, e;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    model(32'hFFFF, 2);
    run_dump(16'hFFFF, 16'd2, 0, 0, to);
    total++; d = first_diff(g, e);
    if (to || d != -1) begin bad++; $display("FAIL wrap_stream at=%0d got=%0d exp=%0d to=%b", d, g, e, to); end
    total++;
    if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 13'h1FFF || rd_addr_q[1] !== 13'h0000) begin
      bad++; $display("FAIL wrap_mem_addr got_n=%0d exp=1FFF,0000", rd_addr_q.size());
    end
  endtask

  task automatic test_backpressure;
    bit to; int d, g, e;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    model(32'h0A30, 5);
    run_dump(16'h0A30, 16'd5, 2, 0, to);
    total++; d = first_diff(g, e);
    if (to || d != -1) begin bad++; $display("FAIL stall_stream at=%0d got=%0d exp=%0d to=%b", d, g, e, to); end
    total++; if (stab_bad != 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", stab_bad); end
    total++; if (rd_count != 5) begin bad++; $display("FAIL stall_rd got=%0d exp=5", rd_count); end
  endtask

  task automatic test_random;
    bit to; int d, g, e, ab;
    logic [15:0] sa, len;
    logic [AW-1:0] ea;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
      sa  = 16'($urandom);
      len = 16'($urandom_range(0, 40));
      model(int'(sa), int'(len));
      run_dump(sa, len, 1, (it % 2) == 1, to);
      total++; d = first_diff(g, e);
      if (to || d != -1) begin bad++; $display("FAIL rand%0d_stream at=%0d got=%0d exp=%0d to=%b", it, d, g, e, to); end
      total++; if (rd_count != int'(len)) begin bad++; $display("FAIL rand%0d_rd got=%0d exp=%0d", it, rd_count, len); end
      total++; if (done_count != 1) begin bad++; $display("FAIL rand%0d_done got=%0d exp=1", it, done_count); end
      total++; if (stab_bad != 0) begin bad++; $display("FAIL rand%0d_hold got=%0d exp=0", it, stab_bad); end
      ab = 0;
      for (int i = 0; i < int'(len); i++) begin
        ea = AW'(int'(sa) + i);
        if (i >= rd_addr_q.size() || rd_addr_q[i] !== ea) ab++;
      end
      total++; if (ab != 0) begin bad++; $display("FAIL rand%0d_addr got=%0d_bad exp=0", it, ab); end
    end
  endtask

  task automatic test_reset_mid;
    bit to; int d, g, e, cyc, n_before;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    got_q.delete(); held_pending = 0; stab_bad = 0;
    @(posedge clk); #1;
    out_ready = 1; start_addr = 16'h0040; length = 16'd20; start = 1; mon_en = 1;
    @(posedge clk); #1;
    start = 0;
    cyc = 0;
    while (!(got_q.size() == 9 && out_valid) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (cyc >= 200) begin bad++; $display("FAIL rstmid_reach got=timeout exp=data_hi"); end
    total++; if (out_data !== hexc(int'(mem[16'h0040]) >> 4)) begin
      bad++; $display("FAIL rstmid_data_hi got=%h exp=%h", out_data, hexc(int'(mem[16'h0040]) >> 4));
    end
    #2; reset = 1; #1;
    total++; if (out_valid !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
      bad++; $display("FAIL rstmid_async got=v%b r%b b%b d%h exp=v0 r0 b0 d00", out_valid, mem_rd, busy, out_data);
    end
    n_before = got_q.size();
    repeat (3) @(posedge clk);
    #1; reset = 0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (got_q.size() != n_before || out_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_silent got=%0d exp=%0d", got_q.size(), n_before);
    end
    mon_en = 0;
    model(32'h0040, 20);
    run_dump(16'h0040, 16'd20, 1, 0, to);
    total++; d = first_diff(g, e);
    if (to || d != -1) begin bad++; $display("FAIL rstmid_restart at=%0d got=%0d exp=%0d to=%b", d, g, e, to); end
    total++; if (done_count != 1) begin bad++; $display("FAIL rstmid_done got=%0d exp=1", done_count); end
  endtask

  initial begin
`ifdef HEX_CRLF_EN
    eol_s = "\r\n";
`else
    eol_s = "\n";
`endif
    reset = 1; start = 0; start_addr = '0; length = '0; out_ready = 1;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    test_reset;
    test_spec_example;
    test_zero_length;
    test_multi_record;
    test_addr_wrap;
    test_backpressure;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/samples_mem_hex_dump.md
SAMPLES_MEM_HEX_DUMP -- requirements
Module: samples_mem_hex_dump

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 13, width of the memory address; DATA_WIDTH, default 8, memory word width (only 8 supported); REC_LEN, default 16, maximum data bytes per record (1..255).
REQ-002 SHALL have ports: clk, in, 1, sole clock; reset, in, 1, asynchronous active-high reset.
REQ-003 SHALL have ports: start, in, 1, one-cycle request to begin a dump; start_addr, in, 16, first byte address; length, in, 16, byte count.
REQ-004 SHALL have ports: mem_addr, out, ADDR_WIDTH, read address; mem_rd, out, 1, read strobe; mem_data, in, 8, read data, valid exactly 1 cycle after mem_rd.
REQ-005 SHALL have ports: out_data, out, 8, ASCII character; out_valid, out, 1, character valid; out_ready, in, 1, sink accepts.
REQ-006 SHALL have ports: busy, out, 1, dump in progress; done, out, 1, one-cycle pulse after the final character is accepted.

Function
REQ-007 SHALL emit an Intel HEX stream: data records ":LLAAAA00<data>CC" plus line end, then EOF record ":00000001FF" plus line end.
REQ-008 SHALL use uppercase hex digits ('0'-'9','A'-'F') only.
REQ-009 SHALL set LL = min(REC_LEN, bytes remaining); every record except possibly the last SHALL carry REC_LEN bytes.
REQ-010 SHALL set AAAA = (start_addr + bytes already emitted) mod 65536; the address SHALL wrap past 0xFFFF without error.
REQ-011 SHALL set CC = two's complement (mod 256) of the 8-bit sum of LL, AAAA high, AAAA low, type, and all data bytes.
REQ-012 SHALL drive mem_addr = low ADDR_WIDTH bits of the current byte address, and SHALL pulse mem_rd for one cycle per data byte.
REQ-013 SHALL capture mem_data on the cycle after mem_rd, before presenting that byte's high nibble.
REQ-014 SHALL transfer a character only on a cycle where out_valid and out_ready are both 1.
REQ-015 SHALL hold out_data stable while out_valid=1 and out_ready=0, and SHALL never deassert out_valid before the transfer.
REQ-016 SHALL present at most one character per cycle; with out_ready held at 1, no more than 1 idle cycle per data byte is permitted (the fetch cycle).
REQ-017 SHALL implement states IDLE, COLON, LEN_HI, LEN_LO, ADDR3..ADDR0, TYPE_HI, TYPE_LO, FETCH, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, EOL, EOF_REC and DONE.
REQ-018 Transitions: IDLE->COLON on start; TYPE_LO->FETCH if LL>0, else ->CSUM_HI; DATA_LO->FETCH while the record has bytes left, else ->CSUM_HI; EOL->COLON if bytes remain, else ->EOF_REC; EOF_REC->DONE after its final line-end character; DONE->IDLE in 1 cycle with done=1.
REQ-019 With length=0, SHALL emit only the EOF record.
REQ-020 SHALL ignore start while busy=1; busy SHALL be 1 from the cycle after start until DONE.
REQ-021 SHALL latch start_addr and length at start; later input changes SHALL have no effect on the dump in progress.

Reset
REQ-022 reset SHALL force IDLE immediately, regardless of clk.
REQ-023 On reset, SHALL drive out_valid=0, mem_rd=0, busy=0, done=0, out_data=0x00 and mem_addr=0.
REQ-024 After reset is asserted mid-dump, no further characters SHALL be emitted; the next start SHALL produce a complete, correct stream.

Configuration
REQ-025 Macro HEX_CRLF_EN defined: each line end SHALL be CR (0x0D) followed by LF (0x0A).
REQ-026 Macro HEX_CRLF_EN undefined: each line end SHALL be LF (0x0A) only, and CR SHALL never be emitted.

Verification
REQ-027 start_addr=0x0000, length=2, mem[0]=0x3E, mem[1]=0x55, out_ready=1, CRLF on -> ":020000003E556B\r\n:00000001FF\r\n", then a single done pulse.
REQ-028 length=0 -> exactly ":00000001FF\r\n", no mem_rd pulses, done pulse.
REQ-029 start_addr=0x0100, length=17 -> first record header ":10010000", then ":01011000"; each checksum correct; 17 mem_rd pulses.
REQ-030 start_addr=0xFFFF, length=2 -> record addresses FFFF then 0000 across two records when REC_LEN=1; mem_addr wraps to 0x1FFF then 0x0000.
REQ-031 out_ready held 0 for 5 cycles mid-data -> out_data unchanged and out_valid=1 throughout; stream identical to the no-backpressure run.
REQ-032 reset pulsed during DATA_HI, then start again -> out_valid=0 immediately on reset; second stream complete and correct. With HEX_CRLF_EN undefined, REQ-027 yields the same stream with "\n" line ends only.
